// File: rtl/prescaler0_sync.sv
// prescaler0_sync
//   Shared 10-bit prescaler for the synchronous timer/counters TC0, TC1, TC3
//   and TC4. It produces single-cycle clock-enable pulses every 8, 64, 256
//   and 1024 running cycles. It also owns the TSM and PSRSYNC bits of GTCCR,
//   which give a software prescaler reset and a hold mode for synchronised
//   timer starts.
//
// Ports
//   clk         io clock
//   rst         synchronous active-high reset
//   gtccr_we    GTCCR write strobe (one cycle)
//   gtccr_din   GTCCR write data
//   gtccr_dout  GTCCR read data (TSM, PSRSYNC, other bits 0)
//   clk8en      enable pulse, once per 8 running cycles
//   clk64en     enable pulse, once per 64 running cycles
//   clk256en    enable pulse, once per 256 running cycles
//   clk1024en   enable pulse, once per 1024 running cycles
//   presc_cnt   current prescaler count (debug)
//   sync_halt   high while the prescaler is held; the timers freeze
module prescaler0_sync #(
  parameter int P_TSM_BIT     = 7,
  parameter int P_PSRSYNC_BIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gtccr_we,
  input  logic [7:0] gtccr_din,
  output logic [7:0] gtccr_dout,
  output logic       clk8en,
  output logic       clk64en,
  output logic       clk256en,
  output logic       clk1024en,
  output logic [9:0] presc_cnt,
  output logic       sync_halt
);

  // The PSRSYNC bit is the FSM state: RUN (PSRSYNC=0) or HOLD (PSRSYNC=1).
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_tsm;
  logic [9:0] r_cnt;

  logic       w_wr_tsm;
  logic       w_wr_psr;
  logic       w_tsm_next;
  logic       w_clear;
  logic       w_held;
  logic       w_unused_din;

  assign w_wr_tsm   = gtccr_din[P_TSM_BIT];
  assign w_wr_psr   = gtccr_din[P_PSRSYNC_BIT];
  assign w_tsm_next = gtccr_we ? w_wr_tsm : r_tsm;
  assign w_clear    = gtccr_we & w_wr_psr;
  assign w_held     = (r_state == ST_HOLD);

  // Only the TSM and PSRSYNC bits of the write data are architected.
  assign w_unused_din = ^gtccr_din;

  // HOLD is left as soon as TSM is 0 after the edge, which clears PSRSYNC
  // in hardware; a PSRSYNC write without TSM never enters HOLD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_clear && w_wr_tsm) w_state_next = ST_HOLD;
      ST_HOLD: if (!w_tsm_next)         w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // The count is forced to 0 during the whole hold (including the release
  // edge) and on any PSRSYNC write; the clear takes priority over the wrap
  // increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_tsm   <= 1'b0;
      r_cnt   <= 10'd0;
    end else begin
      r_state <= w_state_next;
      r_tsm   <= w_tsm_next;
      if (w_held || w_clear) begin
        r_cnt <= 10'd0;
      end else begin
        r_cnt <= r_cnt + 10'd1;
      end
    end
  end

  // Enables decode the registered count, so a clear at edge E suppresses
  // whatever pulse the next count value would have produced.
  assign clk8en    = ~w_held & (&r_cnt[2:0]);
  assign clk64en   = ~w_held & (&r_cnt[5:0]);
  assign clk256en  = ~w_held & (&r_cnt[7:0]);
  assign clk1024en = ~w_held & (&r_cnt);

  always_comb begin
    gtccr_dout                = 8'h00;
    gtccr_dout[P_TSM_BIT]     = r_tsm;
    gtccr_dout[P_PSRSYNC_BIT] = w_held;
  end

  assign presc_cnt = r_cnt;
  assign sync_halt = w_held;

endmodule

// File: tb/tb_prescaler0_sync.sv
module tb_prescaler0_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gtccr_we = 1'b0;
  logic [7:0] gtccr_din = 8'h00;
  logic [7:0] gtccr_dout;
  logic       clk8en, clk64en, clk256en, clk1024en;
  logic [9:0] presc_cnt;
  logic       sync_halt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: count as an integer, TSM/PSRSYNC as plain bits.
  int m_cnt = 0;
  bit m_tsm = 1'b0;
  bit m_psr = 1'b0;

  always #5 clk = ~clk;

  prescaler0_sync dut (
    .clk        (clk),
    .rst        (rst),
    .gtccr_we   (gtccr_we),
    .gtccr_din  (gtccr_din),
    .gtccr_dout (gtccr_dout),
    .clk8en     (clk8en),
    .clk64en    (clk64en),
    .clk256en   (clk256en),
    .clk1024en  (clk1024en),
    .presc_cnt  (presc_cnt),
    .sync_halt  (sync_halt)
  );

  function automatic logic [3:0] exp_en();
    logic [3:0] e;
    e = 4'b0000;
    if (!m_psr) begin
      e[3] = (m_cnt % 8) == 7;
      e[2] = (m_cnt % 64) == 63;
      e[1] = (m_cnt % 256) == 255;
      e[0] = m_cnt == 1023;
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_dout();
    return {m_tsm, 6'b000000, m_psr};
  endfunction

  // One clock: drive inputs, take the edge, advance the model, sample 1ns later.
  task automatic tick(input logic r, input logic we, input logic [7:0] din);
    bit clear, was_held, tsm_after;
    rst = r; gtccr_we = we; gtccr_din = din;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_tsm = 1'b0; m_psr = 1'b0;
    end else begin
      clear     = we && din[0];
      was_held  = m_psr;
      tsm_after = we ? din[7] : m_tsm;
      m_psr     = (we && din[0] && din[7]) || (m_psr && tsm_after);
      m_tsm     = tsm_after;
      m_cnt     = (was_held || clear) ? 0 : (m_cnt + 1) % 1024;
    end
    #1;
    rst = 1'b0; gtccr_we = 1'b0; gtccr_din = 8'h00;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (presc_cnt !== 10'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", presc_cnt); end
    checks++;
    if (gtccr_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h expected 00", gtccr_dout); end
    checks++;
    if ({clk8en, clk64en, clk256en, clk1024en, sync_halt} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got %b expected 00000", {clk8en, clk64en, clk256en, clk1024en, sync_halt});
    end
  endtask

  task automatic test_free_run();
    logic [3:0] e;
    for (int c = 1; c <= 2048; c++) begin
      if (c > 1) tick(1'b0, 1'b0, 8'h00);
      e = {(c % 8) == 0, (c % 64) == 0, (c % 256) == 0, (c % 1024) == 0};
      checks++;
      if (presc_cnt !== 10'((c - 1) % 1024)) begin
        errors++; $display("FAIL free_run_cnt cycle %0d got %0d expected %0d", c, presc_cnt, (c - 1) % 1024);
      end
      checks++;
      if ({clk8en, clk64en, clk256en, clk1024en} !== e) begin
        errors++; $display("FAIL free_run_en cycle %0d got %b expected %b", c, {clk8en, clk64en, clk256en, clk1024en}, e);
      end
    end
  endtask

  task automatic test_psr_reset();
    int n = 0;
    while (m_cnt != 500 && n < 2048) begin tick(1'b0, 1'b0, 8'h00); n++; end
    checks++;
    if (presc_cnt !== 10'd500) begin errors++; $display("FAIL psr_reach500 got %0d expected 500", presc_cnt); end
    tick(1'b0, 1'b1, 8'h01);
    checks++;
    if (presc_cnt !== 10'd0) begin errors++; $display("FAIL psr_cnt got %0d expected 0", presc_cnt); end
    checks++;
    if (gtccr_dout !== 8'h00 || sync_halt !== 1'b0) begin
      errors++; $display("FAIL psr_dout got %h/%b expected 00/0", gtccr_dout, sync_halt);
    end
    for (int i = 1; i <= 64; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      checks++;
      if (clk64en !== ((i % 64) == 63)) begin
        errors++; $display("FAIL psr_clk64en i=%0d got %b expected %b", i, clk64en, (i % 64) == 63);
      end
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 1'b1, 8'h81);
    checks++;
    if (gtccr_dout !== 8'h81 || sync_halt !== 1'b1 || presc_cnt !== 10'd0) begin
      errors++; $display("FAIL hold_enter got dout=%h halt=%b cnt=%0d expected 81/1/0", gtccr_dout, sync_halt, presc_cnt);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      checks++;
      if ({clk8en, clk64en, clk256en, clk1024en, sync_halt} !== 5'b00001 || presc_cnt !== 10'd0) begin
        errors++; $display("FAIL hold_idle i=%0d got flags=%b cnt=%0d expected 00001/0", i,
                           {clk8en, clk64en, clk256en, clk1024en, sync_halt}, presc_cnt);
      end
    end
    tick(1'b0, 1'b1, 8'h80);
    checks++;
    if (gtccr_dout !== 8'h81 || sync_halt !== 1'b1 || presc_cnt !== 10'd0) begin
      errors++; $display("FAIL hold_tsm_only got dout=%h halt=%b cnt=%0d expected 81/1/0", gtccr_dout, sync_halt, presc_cnt);
    end
    tick(1'b0, 1'b1, 8'h00);
    checks++;
    if (gtccr_dout !== 8'h00 || sync_halt !== 1'b0 || presc_cnt !== 10'd0) begin
      errors++; $display("FAIL hold_release got dout=%h halt=%b cnt=%0d expected 00/0/0", gtccr_dout, sync_halt, presc_cnt);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      checks++;
      if (clk8en !== (i == 7) || presc_cnt !== 10'(i)) begin
        errors++; $display("FAIL release_clk8en i=%0d got en=%b cnt=%0d expected %b/%0d", i, clk8en, presc_cnt, i == 7, i);
      end
    end
  endtask

  task automatic test_wrap_clear();
    int n = 0;
    int pulses = 0;
    while (m_cnt != 1023 && n < 2048) begin tick(1'b0, 1'b0, 8'h00); n++; end
    checks++;
    if ({clk8en, clk64en, clk256en, clk1024en} !== 4'hF || presc_cnt !== 10'd1023) begin
      errors++; $display("FAIL wrap_all_en got en=%b cnt=%0d expected 1111/1023", {clk8en, clk64en, clk256en, clk1024en}, presc_cnt);
    end
    tick(1'b0, 1'b1, 8'h01);
    checks++;
    if (presc_cnt !== 10'd0 || clk1024en !== 1'b0) begin
      errors++; $display("FAIL wrap_clear got cnt=%0d en=%b expected 0/0", presc_cnt, clk1024en);
    end
    for (int i = 1; i <= 1023; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (clk1024en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || clk1024en !== 1'b1) begin
      errors++; $display("FAIL wrap_next1024 got pulses=%0d last=%b expected 1/1", pulses, clk1024en);
    end
  endtask

  task automatic test_rst_from_hold();
    tick(1'b0, 1'b1, 8'h81);
    checks++;
    if (sync_halt !== 1'b1) begin errors++; $display("FAIL rsthold_enter got %b expected 1", sync_halt); end
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (gtccr_dout !== 8'h00 || sync_halt !== 1'b0 || presc_cnt !== 10'd0) begin
      errors++; $display("FAIL rsthold_reset got dout=%h halt=%b cnt=%0d expected 00/0/0", gtccr_dout, sync_halt, presc_cnt);
    end
    tick(1'b0, 1'b0, 8'h00);
    checks++;
    if (presc_cnt !== 10'd1) begin errors++; $display("FAIL rsthold_resume got %0d expected 1", presc_cnt); end
  endtask

  task automatic test_rst_vs_we();
    tick(1'b1, 1'b1, 8'h81);
    checks++;
    if (gtccr_dout !== 8'h00 || sync_halt !== 1'b0 || presc_cnt !== 10'd0) begin
      errors++; $display("FAIL rst_wins got dout=%h halt=%b cnt=%0d expected 00/0/0", gtccr_dout, sync_halt, presc_cnt);
    end
  endtask

  task automatic test_random();
    logic r, we;
    logic [7:0] din;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 7) == 0);
      din = 8'($urandom);
      tick(r, we, din);
      checks++;
      if (presc_cnt !== 10'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt i=%0d got %0d expected %0d", i, presc_cnt, m_cnt);
      end
      checks++;
      if ({clk8en, clk64en, clk256en, clk1024en} !== exp_en() || sync_halt !== m_psr) begin
        errors++; $display("FAIL rand_flags i=%0d got %b/%b expected %b/%b", i,
                           {clk8en, clk64en, clk256en, clk1024en}, sync_halt, exp_en(), m_psr);
      end
      checks++;
      if (gtccr_dout !== exp_dout()) begin
        errors++; $display("FAIL rand_dout i=%0d got %h expected %h", i, gtccr_dout, exp_dout());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_psr_reset();
    test_hold();
    test_wrap_clear();
    test_rst_from_hold();
    test_rst_vs_we();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescaler0_sync.md
Name: prescaler0_sync

Overview:
- Shared 10-bit prescaler for the synchronous timer/counters TC0, TC1, TC3 and TC4.
- Generates the single-cycle clock-enable pulses clk8en, clk64en, clk256en and clk1024en. The per-timer clock-select mux consumes these pulses.
- Owns the TSM and PSRSYNC bits of GTCCR: software prescaler reset, and holding the prescaler in reset to synchronise timer starts.
- Drives a halt flag to the timers while the prescaler is held.

Parameters:
- P_TSM_BIT, 7, GTCCR bit index of TSM.
- P_PSRSYNC_BIT, 0, GTCCR bit index of PSRSYNC.

Ports:
- clk  input  1  io clock
- rst  input  1  synchronous active-high reset
- gtccr_we  input  1  GTCCR write strobe, one cycle
- gtccr_din  input  8  GTCCR write data
- gtccr_dout  output  8  GTCCR read data: TSM at P_TSM_BIT, PSRSYNC at P_PSRSYNC_BIT, all other bits 0
- clk8en  output  1  enable pulse, once per 8 running cycles
- clk64en  output  1  enable pulse, once per 64 running cycles
- clk256en  output  1  enable pulse, once per 256 running cycles
- clk1024en  output  1  enable pulse, once per 1024 running cycles
- presc_cnt  output  10  current prescaler count, for debug/verification
- sync_halt  output  1  high while the prescaler is held; TC0/1/3/4 freeze counting

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt=0, tsm=0, psrsync=0.
  - All enables 0, sync_halt=0, gtccr_dout=0.
  - rst overrides gtccr_we in the same cycle.
- Counter:
  - cnt is 10-bit, increments by 1 per clk when running.
  - Wraps 1023 -> 0 with no extra cycle.
- Enables: decoded combinationally from the registered cnt, gated by ~psrsync.
  - clk8en = (cnt[2:0]==7)
  - clk64en = (cnt[5:0]==63)
  - clk256en = (cnt[7:0]==255)
  - clk1024en = (cnt==1023)
  - When clk1024en=1, all four enables are 1 in that cycle.
  - Each enable is high for exactly one cycle per period.
- Write path, on a clk edge with gtccr_we=1:
  - tsm <= gtccr_din[P_TSM_BIT].
  - If gtccr_din[P_PSRSYNC_BIT]=1: cnt <= 0.
  - psrsync <= 1 only if both gtccr_din[P_PSRSYNC_BIT]=1 and gtccr_din[P_TSM_BIT]=1.
  - Writing 0 to PSRSYNC alone has no effect while TSM stays 1.
- PSRSYNC hardware clear:
  - psrsync_next = (we & din[PSRSYNC] & din[TSM]) | (psrsync & tsm_next).
  - tsm_next is the value of tsm after the current edge.
  - So clearing TSM clears PSRSYNC at the same edge.
  - With TSM=0, PSRSYNC never reads back 1.
- Hold state (psrsync=1):
  - cnt held at 0; all enables forced 0; sync_halt=1.
- Release (write with TSM=0 while held):
  - At edge E: psrsync=0, sync_halt=0, cnt=0.
  - cnt=1 at E+1; first clk8en in the 8th cycle after E (cnt=7).
- Reset-only write (TSM=0, PSRSYNC=1) at edge E:
  - cnt=0 after E; no hold cycle.
  - Next clk8en in the 8th cycle after E.
  - A pending enable pulse that would have fired in the cycle after E is suppressed.
- Read: gtccr_dout reflects the registered tsm/psrsync, valid the cycle after a write.
- States:
  - RUN (psrsync=0) -> HOLD on a write with TSM=1 and PSRSYNC=1.
  - HOLD -> RUN on a write with TSM=0.
  - HOLD -> HOLD on any write with TSM=1.
  - rst forces RUN with cnt=0.
- Simultaneous events: a PSRSYNC write in the wrap cycle (cnt=1023) still shows clk1024en=1 in that cycle; after the edge, cnt=0 (clear wins over increment).

Test Plan:
- Reset, then free run 2048 cycles -> clk8en every 8 cycles, first at cycle 8 (cnt=7); clk1024en at cycles 1024 and 2048; all four enables coincide at cnt=1023.
- Free run to cnt=500, write gtccr_din=8'h01 -> cnt=0 next cycle; gtccr_dout=8'h00; no clk64en until 64 cycles after the write.
- Write 8'h81 -> sync_halt=1, gtccr_dout=8'h81, cnt stays 0, no enables for 100 cycles; write 8'h80 -> still held; write 8'h00 -> sync_halt=0, clk8en exactly 8 cycles later.
- Write 8'h01 in the cycle where cnt=1023 -> clk1024en=1 that cycle; cnt=0 afterwards; next clk1024en 1024 cycles later.
- Hold (8'h81), then assert rst -> tsm=0, psrsync=0, sync_halt=0, gtccr_dout=0, counting resumes from 0.
- Assert rst and gtccr_we=1 with 8'h81 in the same cycle -> reset wins; gtccr_dout=0 next cycle.
